// File: rtl/sync_ff_chain.sv
// sync_ff_chain: reusable multi-flop synchroniser for a single asynchronous bit.
// The first flop may go metastable; later stages give it time to resolve before
// the value reaches q. All flops reset asynchronously to RESET_VAL.
module sync_ff_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  generate
    if (STAGES < 1) begin : g_bad_stages
      $error("sync_ff_chain: STAGES must be >= 1");
    end

    if (STAGES == 1) begin : g_single
      // Single stage: capture the raw input directly.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) s <= RESET_VAL;
        else      s <= d;
      end
    end else begin : g_multi
      // Shift the input through the chain, one stage per clock.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) s <= {STAGES{RESET_VAL}};
        else      s <= {s[STAGES-2:0], d};
      end
    end
  endgenerate

  assign q = s[STAGES-1];

endmodule

// File: rtl/falling_edge_detector.sv
// falling_edge_detector: synchronises an asynchronous level, optionally
// debounces it, and emits a one-clock pulse for each accepted 1->0 transition.
// The debounced level starts at 0, so an input low through reset never pulses.
module falling_edge_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic falling_edge
);

  localparam int             CW   = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]  LAST = CW'(FILTER_LEN - 1);

  generate
    if (SYNC_STAGES < 1) begin : g_bad_sync
      $error("falling_edge_detector: SYNC_STAGES must be >= 1");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
      $error("falling_edge_detector: FILTER_LEN must be >= 1");
    end
  endgenerate

  logic          sq;
  logic          lvl;
  logic          lvl_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  sync_ff_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (sq)
  );

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_comb begin
    lvl_next = lvl;
    cnt_next = cnt;
    if (sq == lvl) begin
      cnt_next = '0;
    end else if (cnt == LAST) begin
      lvl_next = sq;
      cnt_next = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Debounced level, run counter and pulse all update on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl          <= 1'b0;
      cnt          <= '0;
      falling_edge <= 1'b0;
    end else begin
      lvl          <= lvl_next;
      cnt          <= cnt_next;
      falling_edge <= lvl & ~lvl_next;
    end
  end

endmodule

// File: tb/tb_falling_edge_detector.sv
// tb_falling_edge_detector: drives two detectors (FILTER_LEN 1 and 3) from the
// same input and compares them with a window-based reference model.
module tb_falling_edge_detector;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic fe1;
  logic fe3;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: recent din samples, accepted levels, expected pulses.
  logic [63:0] hist   = '0;
  logic        lvl1_m = 1'b0;
  logic        lvl3_m = 1'b0;
  logic        exp1   = 1'b0;
  logic        exp3   = 1'b0;

  falling_edge_detector #(.SYNC_STAGES(SYNC), .FILTER_LEN(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .falling_edge (fe1)
  );

  falling_edge_detector #(.SYNC_STAGES(SYNC), .FILTER_LEN(3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .falling_edge (fe3)
  );

  // 40 ns clock period.
  always #20 clk = ~clk;

  // True when the n samples visible to the filter at this edge all equal v.
  function automatic logic window_is(input logic [63:0] h, input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      if (h[SYNC + i] !== v) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Model: a level is accepted once the filter window is uniformly opposite.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist   <= '0;
      lvl1_m <= 1'b0;
      lvl3_m <= 1'b0;
      exp1   <= 1'b0;
      exp3   <= 1'b0;
    end else begin
      hist <= {hist[62:0], din};
      exp1 <= lvl1_m && window_is({hist[62:0], din}, 1, 1'b0);
      exp3 <= lvl3_m && window_is({hist[62:0], din}, 3, 1'b0);
      if (window_is({hist[62:0], din}, 1, 1'b0))      lvl1_m <= 1'b0;
      else if (window_is({hist[62:0], din}, 1, 1'b1)) lvl1_m <= 1'b1;
      if (window_is({hist[62:0], din}, 3, 1'b0))      lvl3_m <= 1'b0;
      else if (window_is({hist[62:0], din}, 3, 1'b1)) lvl3_m <= 1'b1;
    end
  end

  task automatic test_reset();
    #5;
    for (int i = 0; i < 6; i++) begin
      din = ~din;
      #10;
      vectors++;
      if (fe1 !== 1'b0 || fe3 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold: fe1=%b fe3=%b expected 0", fe1, fe3);
      end
    end
    din = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (fe1 !== 1'b0 || fe1 !== exp1) begin
        miscompares++;
        $display("[TB] FAIL reset_release cycle %0d: fe1=%b expected 0", i, fe1);
      end
    end
  endtask

  task automatic test_single_fall();
    logic expv;
    @(negedge clk);
    din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (fe1 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rise_no_pulse cycle %0d: fe1=%b expected 0", i, fe1);
      end
    end
    din = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expv = (i == 2);
      vectors++;
      if (fe1 !== expv || fe1 !== exp1) begin
        miscompares++;
        $display("[TB] FAIL single_fall k+%0d: fe1=%b expected %b", i, fe1, expv);
      end
    end
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      #5 din = 1'b1;
      #(g == 0 ? 3 : 7) din = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (fe1 !== 1'b0 || fe3 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL glitch cycle %0d: fe1=%b fe3=%b expected 0", i, fe1, fe3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      din = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      vectors++;
      if (fe1 !== exp1 || (prev === 1'b1 && fe1 === 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL back_to_back cycle %0d: fe1=%b expected %b prev=%b", i, fe1, exp1, prev);
      end
      if (fe1 === 1'b1) pulses++;
      prev = fe1;
    end
    din = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fe1 === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 6) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_count: got %0d pulses expected 6", pulses);
    end
  endtask

  task automatic test_filter();
    logic expv;
    din = 1'b1;
    repeat (8) @(negedge clk);
    din = 1'b0;
    repeat (2) @(negedge clk);
    din = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (fe3 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL filter_short_low cycle %0d: fe3=%b expected 0", i, fe3);
      end
    end
    din = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) din = 1'b1;
      expv = (i == 4);
      vectors++;
      if (fe3 !== expv || fe3 !== exp3) begin
        miscompares++;
        $display("[TB] FAIL filter_long_low k+%0d: fe3=%b expected %b", i, fe3, expv);
      end
    end
    din = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse();
    bit seen = 0;
    din = 1'b1;
    repeat (4) @(negedge clk);
    din = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (fe1 === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL mid_pulse_wait: fe1 never rose within 10 cycles, expected a pulse");
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (fe1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_pulse_clear: fe1=%b expected 0", fe1);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (fe1 !== 1'b0 || fe3 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mid_pulse_after cycle %0d: fe1=%b fe3=%b expected 0", i, fe1, fe3);
      end
    end
  endtask

  task automatic test_random();
    int p1 = 0;
    int p3 = 0;
    int m1 = 0;
    int m3 = 0;
    int run;
    for (int i = 0; i < 300; ) begin
      din = $urandom_range(1, 0);
      run = $urandom_range(4, 1);
      for (int j = 0; j < run; j++) begin
        @(negedge clk);
        i++;
        vectors++;
        if (fe1 !== exp1 || fe3 !== exp3) begin
          miscompares++;
          $display("[TB] FAIL random cycle %0d: fe1=%b/%b fe3=%b/%b (got/expected)", i, fe1, exp1, fe3, exp3);
        end
        if (fe1 === 1'b1) p1++;
        if (fe3 === 1'b1) p3++;
        if (exp1) m1++;
        if (exp3) m3++;
      end
    end
    vectors++;
    if (p1 != m1 || p3 != m3) begin
      miscompares++;
      $display("[TB] FAIL random_count: f1 %0d/%0d f3 %0d/%0d (got/expected)", p1, m1, p3, m3);
    end
  endtask

  initial begin
    test_reset();
    test_single_fall();
    test_glitch();
    test_back_to_back();
    test_filter();
    test_reset_mid_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
